// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control-FSM bus; master drives op_class/zero_flag/mem_ready, slave (the FSM) drives enables, PC request lines, halted, state, instr_retired
interface multicycle_control_if #(parameter int COUNT_W = 16);
    logic [2:0]         op_class;
    logic               zero_flag;
    logic               mem_ready;
    logic               PCWrite;
    logic               IRWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               RegWrite;
    logic               MemToReg;
    logic               PC4Signal;
    logic               Jump;
    logic               Branch;
    logic               stopBit;
    logic               halted;
    logic [2:0]         state;
    logic [COUNT_W-1:0] instr_retired;
    modport master (
        output op_class, zero_flag, mem_ready,
        input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemToReg,
               PC4Signal, Jump, Branch, stopBit, halted, state, instr_retired
    );
    modport slave (
        input  op_class, zero_flag, mem_ready,
        output PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemToReg,
               PC4Signal, Jump, Branch, stopBit, halted, state, instr_retired
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/exec/mem/wb sequencer; ports clk, reset (sync, active-high), bus (slave: op_class/zero_flag/mem_ready in, datapath enables, PC requests, halted, state, instr_retired out)
module multicycle_control #(
    parameter int COUNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.slave   bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;
    localparam logic [2:0] OP_ALU_R = 3'd0;
    localparam logic [2:0] OP_ALU_I = 3'd1;
    localparam logic [2:0] OP_LW    = 3'd2;
    localparam logic [2:0] OP_SW    = 3'd3;
    localparam logic [2:0] OP_BEQ   = 3'd4;
    localparam logic [2:0] OP_J     = 3'd5;
    localparam logic [2:0] OP_JAL   = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;
    state_e             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               retire;
    logic [2:0]         op;
    logic               is_sw;
    assign op    = bus.op_class;
    assign is_sw = op == OP_SW;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d       = state_q;
        bus.PCWrite   = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemToReg  = 1'b0;
        bus.PC4Signal = 1'b0;
        bus.Jump      = 1'b0;
        bus.Branch    = 1'b0;
        bus.stopBit   = 1'b0;
        bus.halted    = 1'b0;
        case (state_q)
            FETCH: begin
                bus.MemRead = 1'b1;
                state_d     = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.IRWrite   = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.PC4Signal = 1'b1;
                state_d       = EXEC;
            end
            EXEC: begin
                bus.Branch   = op == OP_BEQ;
                bus.Jump     = op == OP_J;
                bus.stopBit  = op == OP_JAL;
                bus.RegWrite = op == OP_JAL;
                bus.PCWrite  = (op == OP_BEQ && bus.zero_flag) || op == OP_J || op == OP_JAL;
                state_d      = (op == OP_ALU_R || op == OP_ALU_I) ? WB :
                               (op == OP_LW || op == OP_SW)      ? MEM :
                               (op == OP_HALT)                   ? HALT : FETCH;
            end
            MEM: begin
                // anything that is not SW behaves as a load here
                bus.MemWrite = is_sw;
                bus.MemRead  = !is_sw;
                state_d      = !bus.mem_ready ? MEM : is_sw ? FETCH : WB;
            end
            WB: begin
                bus.RegWrite = 1'b1;
                bus.MemToReg = op == OP_LW;
                state_d      = FETCH;
            end
            HALT: bus.halted = 1'b1;
            default: state_d = FETCH;
        endcase
    end
    // entering HALT from EXEC retires the HALT instruction itself
    assign retire = (state_q == EXEC || state_q == MEM || state_q == WB) &&
                    (state_d == FETCH || state_d == HALT);
    assign cnt_d  = cnt_q + COUNT_W'(retire);
    assign bus.state         = state_q;
    assign bus.instr_retired = cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multicycle control FSM with a 4-bit retire counter
module tb_multicycle_control;
    localparam int W = 4;
    localparam logic [10:0] C_F    = 11'h080;
    localparam logic [10:0] C_D    = 11'h308;
    localparam logic [10:0] C_0    = 11'h000;
    localparam logic [10:0] C_BT   = 11'h202;
    localparam logic [10:0] C_BN   = 11'h002;
    localparam logic [10:0] C_J    = 11'h204;
    localparam logic [10:0] C_JAL  = 11'h221;
    localparam logic [10:0] C_MLW  = 11'h080;
    localparam logic [10:0] C_MSW  = 11'h040;
    localparam logic [10:0] C_WB   = 11'h020;
    localparam logic [10:0] C_WBLW = 11'h030;
    localparam logic [10:0] C_H    = 11'h400;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    multicycle_control_if #(.COUNT_W(W)) bus ();
    multicycle_control #(.COUNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [10:0] ctl();
        return {bus.halted, bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite,
                bus.MemToReg, bus.PC4Signal, bus.Jump, bus.Branch, bus.stopBit};
    endfunction
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    // apply inputs, check state/outputs/request-line invariant, then advance one clock
    task automatic cyc(input string tag, input logic [2:0] op, input logic z, input logic rdy,
                       input logic [2:0] st, input logic [10:0] c);
        bus.op_class  = op;
        bus.zero_flag = z;
        bus.mem_ready = rdy;
        #1;
        chk({tag, " state"}, 16'(bus.state), 16'(st));
        chk({tag, " ctl"}, 16'(ctl()), 16'(c));
        chk({tag, " onehot"}, 16'($countones({bus.PC4Signal, bus.Jump, bus.Branch, bus.stopBit}) <= 1), 16'd1);
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk({tag, " rst state"}, 16'(bus.state), 16'd0);
        chk({tag, " rst cnt"}, 16'(bus.instr_retired), 16'd0);
        chk({tag, " rst ctl"}, 16'(ctl()), 16'(C_F));
    endtask
    initial begin
        bus.op_class  = 3'd0;
        bus.zero_flag = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset("init");
        cyc("alur f", 3'd0, 1'b0, 1'b1, 3'd0, C_F);
        cyc("alur d", 3'd0, 1'b0, 1'b1, 3'd1, C_D);
        cyc("alur e", 3'd0, 1'b0, 1'b1, 3'd2, C_0);
        cyc("alur w", 3'd0, 1'b0, 1'b1, 3'd4, C_WB);
        chk("alur end state", 16'(bus.state), 16'd0);
        chk("alur cnt", 16'(bus.instr_retired), 16'd1);
        cyc("lw f0", 3'd2, 1'b0, 1'b0, 3'd0, C_F);
        cyc("lw f1", 3'd2, 1'b0, 1'b0, 3'd0, C_F);
        cyc("lw f2", 3'd2, 1'b0, 1'b1, 3'd0, C_F);
        cyc("lw d", 3'd2, 1'b0, 1'b1, 3'd1, C_D);
        cyc("lw e", 3'd2, 1'b0, 1'b0, 3'd2, C_0);
        cyc("lw m0", 3'd2, 1'b0, 1'b0, 3'd3, C_MLW);
        cyc("lw m1", 3'd2, 1'b0, 1'b0, 3'd3, C_MLW);
        cyc("lw m2", 3'd2, 1'b0, 1'b0, 3'd3, C_MLW);
        cyc("lw m3", 3'd2, 1'b0, 1'b1, 3'd3, C_MLW);
        cyc("lw w", 3'd2, 1'b0, 1'b0, 3'd4, C_WBLW);
        chk("lw cnt", 16'(bus.instr_retired), 16'd2);
        cyc("beqt f", 3'd4, 1'b1, 1'b1, 3'd0, C_F);
        cyc("beqt d", 3'd4, 1'b1, 1'b0, 3'd1, C_D);
        cyc("beqt e", 3'd4, 1'b1, 1'b0, 3'd2, C_BT);
        cyc("beqn f", 3'd4, 1'b0, 1'b1, 3'd0, C_F);
        cyc("beqn d", 3'd4, 1'b0, 1'b1, 3'd1, C_D);
        cyc("beqn e", 3'd4, 1'b0, 1'b1, 3'd2, C_BN);
        chk("beq cnt", 16'(bus.instr_retired), 16'd4);
        cyc("j f", 3'd5, 1'b0, 1'b1, 3'd0, C_F);
        cyc("j d", 3'd5, 1'b0, 1'b1, 3'd1, C_D);
        cyc("j e", 3'd5, 1'b0, 1'b1, 3'd2, C_J);
        cyc("jal f", 3'd6, 1'b0, 1'b1, 3'd0, C_F);
        cyc("jal d", 3'd6, 1'b0, 1'b1, 3'd1, C_D);
        cyc("jal e", 3'd6, 1'b0, 1'b1, 3'd2, C_JAL);
        chk("jal cnt", 16'(bus.instr_retired), 16'd6);
        cyc("sw f", 3'd3, 1'b0, 1'b1, 3'd0, C_F);
        cyc("sw d", 3'd3, 1'b0, 1'b1, 3'd1, C_D);
        cyc("sw e", 3'd3, 1'b0, 1'b1, 3'd2, C_0);
        cyc("sw m", 3'd3, 1'b0, 1'b1, 3'd3, C_MSW);
        chk("sw end state", 16'(bus.state), 16'd0);
        chk("sw cnt", 16'(bus.instr_retired), 16'd7);
        cyc("halt f", 3'd7, 1'b0, 1'b1, 3'd0, C_F);
        cyc("halt d", 3'd7, 1'b0, 1'b1, 3'd1, C_D);
        cyc("halt e", 3'd7, 1'b0, 1'b1, 3'd2, C_0);
        chk("halt cnt", 16'(bus.instr_retired), 16'd8);
        for (int i = 0; i < 20; i++)
            cyc($sformatf("halt h%0d", i), 3'(i), 1'b0, 1'(i), 3'd5, C_H);
        chk("halt cnt held", 16'(bus.instr_retired), 16'd8);
        do_reset("halt");
        for (int i = 1; i <= 17; i++) begin
            cyc("alui f", 3'd1, 1'b0, 1'b1, 3'd0, C_F);
            cyc("alui d", 3'd1, 1'b0, 1'b1, 3'd1, C_D);
            cyc("alui e", 3'd1, 1'b0, 1'b1, 3'd2, C_0);
            cyc("alui w", 3'd1, 1'b0, 1'b1, 3'd4, C_WB);
            if (i >= 15)
                chk($sformatf("wrap cnt %0d", i), 16'(bus.instr_retired), 16'(i % 16));
        end
        cyc("swr f", 3'd3, 1'b0, 1'b1, 3'd0, C_F);
        cyc("swr d", 3'd3, 1'b0, 1'b1, 3'd1, C_D);
        cyc("swr e", 3'd3, 1'b0, 1'b1, 3'd2, C_0);
        cyc("swr m", 3'd3, 1'b0, 1'b0, 3'd3, C_MSW);
        do_reset("mem");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
